// File: rtl/ypbpr_in.sv
// Pipelined YPbPr-to-RGB decoder with bypass and sync delay matched to the pixel path.
// Optional macro YPBPR_IN_CLAMP_EN clamps studio-range input codes before offset removal.
module ypbpr_in #(
  parameter int PIPE_EXTRA = 0
) (
  input  logic        clk_vid,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        ypbpr_en,
  input  logic        ypbpr_full,
  input  logic [23:0] din,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  output logic [23:0] dout,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out
);

  logic mode_en_reg, mode_full_reg, vs_prev_reg;
  logic vs_rise;

  assign vs_rise = vs_in & ~vs_prev_reg;

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      mode_en_reg   <= 1'b0;
      mode_full_reg <= 1'b0;
      vs_prev_reg   <= 1'b0;
    end else if (ce_pix) begin
      vs_prev_reg <= vs_in;
      if (vs_rise) begin
        mode_en_reg   <= ypbpr_en;
        mode_full_reg <= ypbpr_full;
      end
    end
  end

  // Stage 1: offset removal. The mode travels with each pixel so stages 2/3 use the
  // mode the pixel entered with, keeping a frame from mixing modes mid-pipeline.
  logic [7:0]        pr_c, y_c, pb_c;
  logic signed [9:0] y1_next, u1_next, v1_next;

  always_comb begin
    pr_c = din[23:16];
    y_c  = din[15:8];
    pb_c = din[7:0];
`ifdef YPBPR_IN_CLAMP_EN
    if (!mode_full_reg) begin
      if (y_c < 8'd16)  y_c = 8'd16;
      if (y_c > 8'd235) y_c = 8'd235;
      if (pr_c < 8'd16)  pr_c = 8'd16;
      if (pr_c > 8'd240) pr_c = 8'd240;
      if (pb_c < 8'd16)  pb_c = 8'd16;
      if (pb_c > 8'd240) pb_c = 8'd240;
    end
`endif
    y1_next = mode_full_reg ? $signed({2'b00, y_c}) : $signed({2'b00, y_c}) - 10'sd16;
    u1_next = $signed({2'b00, pb_c}) - 10'sd128;
    v1_next = $signed({2'b00, pr_c}) - 10'sd128;
  end

  logic signed [9:0] y1_reg, u1_reg, v1_reg;
  logic [23:0]       raw1_reg;
  logic              en1_reg, full1_reg;
  logic [2:0]        sync1_reg;

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      y1_reg    <= '0;
      u1_reg    <= '0;
      v1_reg    <= '0;
      raw1_reg  <= '0;
      en1_reg   <= 1'b0;
      full1_reg <= 1'b0;
      sync1_reg <= '0;
    end else if (ce_pix) begin
      y1_reg    <= y1_next;
      u1_reg    <= u1_next;
      v1_reg    <= v1_next;
      raw1_reg  <= din;
      en1_reg   <= mode_en_reg;
      full1_reg <= mode_full_reg;
      sync1_reg <= {hs_in, vs_in, de_in};
    end
  end

  // Stage 2: products with x256 coefficients.
  logic signed [20:0] ky_c, rv_c, gu_c, gv_c, bu_c;
  logic signed [20:0] y1_ext, u1_ext, v1_ext;

  always_comb begin
    y1_ext = 21'(y1_reg);
    u1_ext = 21'(u1_reg);
    v1_ext = 21'(v1_reg);
    if (full1_reg) begin
      ky_c = 21'sd256;
      rv_c = 21'sd359;
      gu_c = 21'sd88;
      gv_c = 21'sd183;
      bu_c = 21'sd454;
    end else begin
      ky_c = 21'sd298;
      rv_c = 21'sd409;
      gu_c = 21'sd100;
      gv_c = 21'sd208;
      bu_c = 21'sd516;
    end
  end

  logic signed [20:0] p_ky_reg, p_rv_reg, p_gu_reg, p_gv_reg, p_bu_reg;
  logic [23:0]        raw2_reg;
  logic               en2_reg;
  logic [2:0]         sync2_reg;

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      p_ky_reg  <= '0;
      p_rv_reg  <= '0;
      p_gu_reg  <= '0;
      p_gv_reg  <= '0;
      p_bu_reg  <= '0;
      raw2_reg  <= '0;
      en2_reg   <= 1'b0;
      sync2_reg <= '0;
    end else if (ce_pix) begin
      p_ky_reg  <= ky_c * y1_ext;
      p_rv_reg  <= rv_c * v1_ext;
      p_gu_reg  <= gu_c * u1_ext;
      p_gv_reg  <= gv_c * v1_ext;
      p_bu_reg  <= bu_c * u1_ext;
      raw2_reg  <= raw1_reg;
      en2_reg   <= en1_reg;
      sync2_reg <= sync1_reg;
    end
  end

  // Stage 3: sum with rounding, arithmetic shift, saturate to 0..255.
  function automatic logic [7:0] sat8(input logic signed [22:0] s);
    if (s < 23'sd0)
      return 8'd0;
    else if (s > 23'sd255)
      return 8'd255;
    else
      return s[7:0];
  endfunction

  logic signed [22:0] r_sum, g_sum, b_sum;
  logic [23:0]        pix3_next;

  always_comb begin
    r_sum = (23'(p_ky_reg) + 23'(p_rv_reg) + 23'sd128) >>> 8;
    g_sum = (23'(p_ky_reg) - 23'(p_gu_reg) - 23'(p_gv_reg) + 23'sd128) >>> 8;
    b_sum = (23'(p_ky_reg) + 23'(p_bu_reg) + 23'sd128) >>> 8;
    pix3_next = en2_reg ? {sat8(r_sum), sat8(g_sum), sat8(b_sum)} : raw2_reg;
  end

  logic [26:0] stage3_reg;

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset)
      stage3_reg <= '0;
    else if (ce_pix)
      stage3_reg <= {sync2_reg, pix3_next};
  end

  logic [26:0] pipe_out;

  generate
    if (PIPE_EXTRA > 0) begin : g_extra
      logic [26:0] ext_reg [PIPE_EXTRA];

      always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_EXTRA; i++)
            ext_reg[i] <= '0;
        end else if (ce_pix) begin
          ext_reg[0] <= stage3_reg;
          for (int i = 1; i < PIPE_EXTRA; i++)
            ext_reg[i] <= ext_reg[i-1];
        end
      end

      assign pipe_out = ext_reg[PIPE_EXTRA-1];
    end else begin : g_no_extra
      assign pipe_out = stage3_reg;
    end
  endgenerate

  assign {hs_out, vs_out, de_out, dout} = pipe_out;

endmodule

// File: tb/tb_ypbpr_in.sv
// Self-checking bench for ypbpr_in: directed test-plan pixels plus a randomized run
// compared against an arithmetic reference model with an enabled-cycle delay queue.
module tb_ypbpr_in;
  localparam int PIPE_EXTRA = 0;
  localparam int LAT = 3 + PIPE_EXTRA;

  logic        clk_vid = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic        ypbpr_en;
  logic        ypbpr_full;
  logic [23:0] din;
  logic        hs_in, vs_in, de_in;
  logic [23:0] dout;
  logic        hs_out, vs_out, de_out;

  int errors = 0;
  int checks = 0;

  logic [26:0] exp_q[$];
  logic [26:0] exp_cur;
  bit          m_en, m_full, m_vs_prev;

  ypbpr_in #(.PIPE_EXTRA(PIPE_EXTRA)) dut (
    .clk_vid    (clk_vid),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .ypbpr_en   (ypbpr_en),
    .ypbpr_full (ypbpr_full),
    .din        (din),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .de_in      (de_in),
    .dout       (dout),
    .hs_out     (hs_out),
    .vs_out     (vs_out),
    .de_out     (de_out)
  );

  always #5 clk_vid = ~clk_vid;

  function automatic logic [7:0] sat(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return x[7:0];
  endfunction

  // Reference conversion straight from the colour equations.
  function automatic logic [23:0] model_px(input logic [23:0] px, input bit en, input bit full);
    int pr, yy, pb, y, u, v, ky, kr, kgu, kgv, kb;
    if (!en) return px;
    pr = int'(px[23:16]);
    yy = int'(px[15:8]);
    pb = int'(px[7:0]);
`ifdef YPBPR_IN_CLAMP_EN
    if (!full) begin
      yy = (yy < 16) ? 16 : (yy > 235) ? 235 : yy;
      pr = (pr < 16) ? 16 : (pr > 240) ? 240 : pr;
      pb = (pb < 16) ? 16 : (pb > 240) ? 240 : pb;
    end
`endif
    y = full ? yy : yy - 16;
    u = pb - 128;
    v = pr - 128;
    if (full) begin ky = 256; kr = 359; kgu = 88;  kgv = 183; kb = 454; end
    else      begin ky = 298; kr = 409; kgu = 100; kgv = 208; kb = 516; end
    return {sat((ky*y + kr*v + 128) >>> 8),
            sat((ky*y - kgu*u - kgv*v + 128) >>> 8),
            sat((ky*y + kb*u + 128) >>> 8)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    repeat (LAT - 1) exp_q.push_back(27'd0);
    exp_cur   = 27'd0;
    m_en      = 1'b0;
    m_full    = 1'b0;
    m_vs_prev = 1'b0;
  endtask

  task automatic step(input bit ce, input logic [23:0] d, input bit hs, input bit vs, input bit de);
    ce_pix = ce;
    din    = d;
    hs_in  = hs;
    vs_in  = vs;
    de_in  = de;
    @(posedge clk_vid);
    #1;
    if (ce) begin
      exp_q.push_back({hs, vs, de, model_px(d, m_en, m_full)});
      if (vs && !m_vs_prev) begin
        m_en   = ypbpr_en;
        m_full = ypbpr_full;
      end
      m_vs_prev = vs;
      exp_cur   = exp_q.pop_front();
    end
    checks++;
    assert ({hs_out, vs_out, de_out, dout} === exp_cur)
      else begin
        errors++;
        $error("FAIL pipe: got hs/vs/de/dout=%b%b%b/%h want %b%b%b/%h", hs_out, vs_out, de_out, dout,
               exp_cur[26], exp_cur[25], exp_cur[24], exp_cur[23:0]);
      end
  endtask

  task automatic vs_pulse();
    step(1'b1, 24'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 24'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_px(input string tag, input logic [23:0] want);
    checks++;
    assert (dout === want)
      else begin
        errors++;
        $error("FAIL %s: got dout=%h want %h", tag, dout, want);
      end
  endtask

  task automatic px_lat(input string tag, input logic [23:0] d, input logic [23:0] want);
    repeat (LAT) step(1'b1, d, 1'b0, 1'b0, 1'b1);
    check_px(tag, want);
  endtask

  initial begin
    reset = 1'b1; ce_pix = 1'b1; ypbpr_en = 1'b0; ypbpr_full = 1'b0;
    din = '0; hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b0;
    repeat (2) @(posedge clk_vid);
    #1;
    checks++;
    assert ({hs_out, vs_out, de_out, dout} === 27'd0)
      else begin errors++; $error("FAIL reset_state: got %h want 0", {hs_out, vs_out, de_out, dout}); end
    reset = 1'b0;
    model_reset();

    // Studio decode
    ypbpr_en = 1'b1; ypbpr_full = 1'b0;
    vs_pulse();
    px_lat("studio_white", 24'h80EB80, 24'hFFFFFF);
    px_lat("studio_black", 24'h801080, 24'h000000);
    px_lat("studio_red",   {8'd240, 8'd81, 8'd90}, 24'hFF0000);

    // Full-range decode
    ypbpr_full = 1'b1;
    vs_pulse();
    px_lat("full_white", 24'h80FF80, 24'hFFFFFF);
    px_lat("full_black", 24'h800080, 24'h000000);
    px_lat("full_grey",  24'h806480, 24'h646464);

    // Bypass with random data and syncs, then 1-of-4 pixel enable
    ypbpr_en = 1'b0; ypbpr_full = 1'b0;
    vs_pulse();
    for (int i = 0; i < 40; i++)
      step(1'b1, 24'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    for (int i = 0; i < 48; i++)
      step((i % 4) == 0, 24'($urandom), 1'($urandom), 1'b0, 1'($urandom));

    // Mode input raised mid-frame: no effect until the next vs rising edge
    ypbpr_en = 1'b1;
    for (int i = 0; i < 10; i++)
      step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b1);
    step(1'b1, 24'h80EB80, 1'b0, 1'b1, 1'b1);
    step(1'b1, 24'h80EB80, 1'b0, 1'b1, 1'b1);
    step(1'b1, 24'h80EB80, 1'b0, 1'b0, 1'b1);
    check_px("edge_pixel_bypassed", 24'h80EB80);
    step(1'b1, 24'h80EB80, 1'b0, 1'b0, 1'b1);
    check_px("post_edge_decoded", 24'hFFFFFF);

    // Random studio and full decode
    for (int i = 0; i < 60; i++)
      step(1'b1, 24'($urandom), 1'($urandom), 1'b0, 1'b1);
    ypbpr_full = 1'b1;
    vs_pulse();
    for (int i = 0; i < 60; i++)
      step(1'b1, 24'($urandom), 1'($urandom), 1'b0, 1'b1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++)
      step(1'b1, 24'($urandom), 1'b1, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    checks++;
    assert ({hs_out, vs_out, de_out, dout} === 27'd0)
      else begin errors++; $error("FAIL async_reset: got %h want 0", {hs_out, vs_out, de_out, dout}); end
    @(posedge clk_vid);
    #1 reset = 1'b0;
    model_reset();
    px_lat("reset_to_bypass", 24'h80EB80, 24'h80EB80);

    // Studio out-of-range codes
    ypbpr_full = 1'b0;
    vs_pulse();
    px_lat("studio_y250", 24'h80FA80, 24'hFFFFFF);
    for (int i = 0; i < 40; i++)
      step(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b1);

    // Random soak: random enables, vs edges and mode inputs
    for (int i = 0; i < 300; i++) begin
      ypbpr_en   = 1'($urandom);
      ypbpr_full = 1'($urandom);
      step($urandom_range(0, 2) != 0, 24'($urandom), 1'($urandom),
           $urandom_range(0, 5) == 0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ypbpr_in.md
Name: ypbpr_in

Overview:
- Pipelined YPbPr-to-RGB decoder; the inverse of the VGA-out RGB-to-YPbPr encoder.
- Sits on the analog-capture / scaler-input path, where component video digitised as {Pr,Y,Pb} must be turned into 24-bit RGB for the scaler.
- Delays hs/vs/de by the same latency as the pixel data, so sync stays aligned with pixels.
- Conversion mode changes only at a frame boundary, so a frame never mixes modes.

Parameters:
- PIPE_EXTRA, 0, number of extra output register stages (0..2), added after stage 3 for timing closure.

Ports:
- clk_vid  in  1  video clock.
- reset  in  1  asynchronous, active-high reset.
- ce_pix  in  1  pixel clock enable; every register advances only when ce_pix=1.
- ypbpr_en  in  1  1 = decode YPbPr; 0 = bypass (data passed through unchanged, still delayed).
- ypbpr_full  in  1  1 = full-range input (Y and Pb/Pr 0..255); 0 = studio range (Y 16..235, Pb/Pr 16..240).
- din  in  24  [23:16]=Pr, [15:8]=Y, [7:0]=Pb.
- hs_in, vs_in, de_in  in  1 each  input syncs and data enable.
- dout  out  24  [23:16]=R, [15:8]=G, [7:0]=B.
- hs_out, vs_out, de_out  out  1 each  delayed syncs and data enable.

Behaviour:
- Reset (async, active-high):
  - clears all pipeline registers: dout=0, hs_out=vs_out=de_out=0;
  - mode registers reset to en=0, full=0 (bypass).
- Mode latch:
  - ypbpr_en and ypbpr_full are sampled into the mode registers on a ce_pix cycle where vs_in=1 and the previous registered vs_in=0 (rising edge).
  - The new mode applies from the next pixel.
  - Changes to the mode inputs at any other time have no effect.
- Latency: 3+PIPE_EXTRA ce_pix-enabled cycles from din to dout, identical for data, hs, vs and de, and identical in bypass and decode modes.
- ce_pix=0: every register holds its value, including the vs edge detector.
- Stage 1 (offset removal):
  - studio mode: y' = Y-16, u = Pb-128, v = Pr-128;
  - full mode: y' = Y, u = Pb-128, v = Pr-128;
  - all three are signed 10-bit.
- Stage 2 (products, signed 21-bit, coefficients x256):
  - studio mode: ky=298, rv=409, gu=100, gv=208, bu=516;
  - full mode: ky=256, rv=359, gu=88, gv=183, bu=454.
- Stage 3 (sum and saturate):
  - R = ky*y' + rv*v + 128
  - G = ky*y' - gu*u - gv*v + 128
  - B = ky*y' + bu*u + 128
  - Each sum is arithmetic-shifted right by 8, then saturated: negative gives 0, >255 gives 255.
- Bypass: din is carried through the same stages unmodified; dout equals din delayed by the pipeline latency.
- Simultaneous events:
  - a vs rising edge and a mode change on the same cycle latch the new mode;
  - the pixel on that cycle is converted in the old mode.
- Reset mid-frame: the pipeline is flushed to zero; after release, the first valid output appears 3+PIPE_EXTRA enabled cycles later.

Optional Feature:
- Macro YPBPR_IN_CLAMP_EN.
- Defined: in studio mode, stage 1 first clamps Y to 16..235 and Pb/Pr to 16..240 before removing the offsets, so out-of-range codes cannot produce overshoot.
- Undefined: no input clamp; out-of-range codes are limited only by the output saturation.
- Full mode and latency are unaffected either way.

Test Plan:
- Studio, full-scale grey. Mode latched (en=1, full=0) via a vs pulse; din={128,235,128} -> dout=0xFFFFFF exactly 3 enabled cycles later. din={128,16,128} -> dout=0x000000.
- Studio, saturated red. din={Pr=240,Y=81,Pb=90} -> R=255, G=0, B=0, which exercises both saturation limits.
- Full-range grey. Latch full=1; din={128,255,128} -> 0xFFFFFF; din={128,0,128} -> 0x000000; din={128,100,128} -> 0x646464.
- Bypass and alignment. Latch en=0; a random din stream with an hs/de pattern -> dout, hs_out and de_out equal the inputs delayed 3 enabled cycles. With ce_pix toggling 1-of-4, the outputs advance only on enabled cycles.
- Mode latch timing. Raise ypbpr_en mid-frame -> output stays bypass until after the next vs_in rising edge; the pixel coincident with that edge is still bypassed.
- Reset mid-stream. Assert reset during active video -> all outputs become 0 immediately (asynchronous) and the mode returns to bypass. With YPBPR_IN_CLAMP_EN defined, din={128,250,128} in studio mode -> 0xFFFFFF with no internal overflow.
